// File: rtl/det_pkg.sv
// Shared types and constants for the serial 3x3 determinant sequencer.
package det_pkg;

    // Default element / determinant width.
    localparam int ELEM_W_DEF = 32;

    // Number of multiply steps in one cofactor expansion.
    localparam logic [3:0] N_STEPS = 4'd9;

    // Row-major element indices.
    localparam logic [3:0] I00 = 4'd0;
    localparam logic [3:0] I01 = 4'd1;
    localparam logic [3:0] I02 = 4'd2;
    localparam logic [3:0] I10 = 4'd3;
    localparam logic [3:0] I11 = 4'd4;
    localparam logic [3:0] I12 = 4'd5;
    localparam logic [3:0] I20 = 4'd6;
    localparam logic [3:0] I21 = 4'd7;
    localparam logic [3:0] I22 = 4'd8;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_CALC = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Multiply-accumulate operation select.
    typedef enum logic [1:0] {
        MAC_PASS = 2'd0,   // y = a*b
        MAC_ADD  = 2'd1,   // y = c + a*b
        MAC_SUB  = 2'd2    // y = c - a*b
    } mac_op_t;

endpackage

// File: rtl/det_mac.sv
// Shared truncated multiplier with add/sub/pass post-op. Purely combinational;
// all results wrap modulo 2^W (low bits of a signed product equal the unsigned ones).
module det_mac
    import det_pkg::*;
#(
    parameter int W = ELEM_W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  mac_op_t      op,
    output logic [W-1:0] y
);

    logic [W-1:0] prod;

    // Truncated product followed by the selected accumulate operation.
    always_comb begin
        prod = a * b;
        case (op)
            MAC_ADD: y = c + prod;
            MAC_SUB: y = c - prod;
            default: y = prod;
        endcase
    end

endmodule

// File: rtl/det3_sequencer.sv
// Serial-load 3x3 determinant engine: nine elements in by valid/ready,
// nine-step cofactor expansion on one shared multiplier, result out by valid/ready.
module det3_sequencer
    import det_pkg::*;
#(
    parameter int ELEM_W = ELEM_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [ELEM_W-1:0] in_data,
    output logic              in_ready,
    output logic              det_valid,
    input  logic              det_ready,
    output logic [ELEM_W-1:0] determinant,
    output logic              busy,
    output logic [15:0]       LED
);

    state_t                  state;
    logic [3:0]              idx;
    logic [3:0]              step;
    logic [8:0][ELEM_W-1:0]  elem;
    logic [ELEM_W-1:0]       tmp;
    logic [ELEM_W-1:0]       acc;

    logic [ELEM_W-1:0]       mac_a;
    logic [ELEM_W-1:0]       mac_b;
    logic [ELEM_W-1:0]       mac_c;
    mac_op_t                 mac_op;
    logic [ELEM_W-1:0]       mac_y;
    logic                    wr_acc;

    // Per-step operand routing: tmp holds the current 2x2 minor,
    // acc collects the signed cofactor terms (steps 2, 5, 8 write acc).
    always_comb begin
        mac_a  = '0;
        mac_b  = '0;
        mac_c  = '0;
        mac_op = MAC_PASS;
        wr_acc = 1'b0;
        case (step)
            4'd0: begin mac_a = elem[I11]; mac_b = elem[I22]; end
            4'd1: begin mac_a = elem[I12]; mac_b = elem[I21]; mac_c = tmp; mac_op = MAC_SUB; end
            4'd2: begin mac_a = elem[I00]; mac_b = tmp; wr_acc = 1'b1; end
            4'd3: begin mac_a = elem[I10]; mac_b = elem[I22]; end
            4'd4: begin mac_a = elem[I12]; mac_b = elem[I20]; mac_c = tmp; mac_op = MAC_SUB; end
            4'd5: begin mac_a = elem[I01]; mac_b = tmp; mac_c = acc; mac_op = MAC_SUB; wr_acc = 1'b1; end
            4'd6: begin mac_a = elem[I10]; mac_b = elem[I21]; end
            4'd7: begin mac_a = elem[I11]; mac_b = elem[I20]; mac_c = tmp; mac_op = MAC_SUB; end
            4'd8: begin mac_a = elem[I02]; mac_b = tmp; mac_c = acc; mac_op = MAC_ADD; wr_acc = 1'b1; end
            default: ;
        endcase
    end

    det_mac #(.W(ELEM_W)) u_mac (
        .a  (mac_a),
        .b  (mac_b),
        .c  (mac_c),
        .op (mac_op),
        .y  (mac_y)
    );

    // Sequencer FSM with registered handshake/status outputs.
    // clear outranks every handshake but leaves the element file and LED intact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_LOAD;
            idx         <= '0;
            step        <= '0;
            in_ready    <= 1'b1;
            det_valid   <= 1'b0;
            busy        <= 1'b0;
            determinant <= '0;
            LED         <= '0;
            elem        <= '0;
            tmp         <= '0;
            acc         <= '0;
        end else if (clear) begin
            state       <= ST_LOAD;
            idx         <= '0;
            step        <= '0;
            in_ready    <= 1'b1;
            det_valid   <= 1'b0;
            busy        <= 1'b0;
            determinant <= '0;
            tmp         <= '0;
            acc         <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (in_valid && in_ready) begin
                        elem[idx] <= in_data;
                        if (idx == I02)
                            LED <= in_data[15:0];
                        if (idx == I22) begin
                            idx      <= '0;
                            step     <= '0;
                            state    <= ST_CALC;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                ST_CALC: begin
                    if (wr_acc)
                        acc <= mac_y;
                    else
                        tmp <= mac_y;
                    if (step == N_STEPS - 4'd1) begin
                        determinant <= mac_y;
                        det_valid   <= 1'b1;
                        step        <= '0;
                        state       <= ST_OUT;
                    end else begin
                        step <= step + 4'd1;
                    end
                end
                ST_OUT: begin
                    if (det_ready) begin
                        det_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_LOAD;
                    end
                end
                default: begin
                    state     <= ST_LOAD;
                    idx       <= '0;
                    step      <= '0;
                    in_ready  <= 1'b1;
                    det_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_det3_sequencer.sv
// Directed + randomized bench for det3_sequencer with a Leibniz-formula reference.
module tb_det3_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         clear;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         det_valid;
    logic         det_ready;
    logic [W-1:0] determinant;
    logic         busy;
    logic [15:0]  led;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mat [9];

    always #5 clk = ~clk;

    det3_sequencer #(.ELEM_W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .det_valid   (det_valid),
        .det_ready   (det_ready),
        .determinant (determinant),
        .busy        (busy),
        .LED         (led)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Leibniz sum over the six permutations, in 64-bit modular arithmetic.
    function automatic logic [W-1:0] det_ref();
        int perm [6][3];
        int sgn  [6];
        bit [63:0] a [9];
        bit [63:0] d;
        bit [63:0] t;
        perm = '{'{0,1,2}, '{1,2,0}, '{2,0,1}, '{0,2,1}, '{1,0,2}, '{2,1,0}};
        sgn  = '{1, 1, 1, -1, -1, -1};
        for (int i = 0; i < 9; i++) a[i] = {{32{mat[i][31]}}, mat[i]};
        d = '0;
        for (int p = 0; p < 6; p++) begin
            t = a[perm[p][0]] * a[3 + perm[p][1]] * a[6 + perm[p][2]];
            if (sgn[p] > 0) d = d + t;
            else            d = d - t;
        end
        return d[W-1:0];
    endfunction

    // Feed the first n elements of mat; starts at a negedge, ends just after the last accepting edge.
    task automatic send_elems(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    in_valid = 1'b0;
                    in_data  = $urandom;
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_data  = mat[i];
            check("in_ready_load", W'(in_ready), W'(1));
            @(posedge clk);
            #1 in_valid = 1'b0;
            if (i < n - 1) @(negedge clk);
        end
    endtask

    // Wait for the result, optionally with junk on the input, hold it for `hold` cycles, then hand it off.
    task automatic get_result(input logic [W-1:0] exp, input bit noise, input int hold);
        int  lat;
        bit  seen;
        seen = 1'b0;
        for (lat = 1; lat <= 40; lat++) begin
            @(negedge clk);
            if (det_valid) begin seen = 1'b1; break; end
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = $urandom;
            end
        end
        in_valid = 1'b0;
        if (!seen) begin
            check("det_valid_timeout", W'(0), W'(1));
            return;
        end
        check("latency", W'(lat), W'(10));
        check("determinant", determinant, exp);
        check("in_ready_out", W'(in_ready), W'(0));
        check("busy_out", W'(busy), W'(1));
        det_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = $urandom;
            end
            @(negedge clk);
            check("hold_valid", W'(det_valid), W'(1));
            check("hold_det", determinant, exp);
            check("hold_in_ready", W'(in_ready), W'(0));
        end
        in_valid  = 1'b0;
        det_ready = 1'b1;
        @(posedge clk);
        #1 det_ready = 1'b0;
        @(negedge clk);
        check("post_valid", W'(det_valid), W'(0));
        check("post_in_ready", W'(in_ready), W'(1));
        check("post_busy", W'(busy), W'(0));
        check("post_det_kept", determinant, exp);
    endtask

    task automatic run_matrix(input bit gaps, input bit noise, input int hold);
        logic [W-1:0] exp;
        exp = det_ref();
        send_elems(9, gaps);
        get_result(exp, noise, hold);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int hits;
        hits = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (det_valid) hits++;
        end
        check(tag, W'(hits), W'(0));
    endtask

    initial begin
        reset     = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        det_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_det_valid", W'(det_valid), W'(0));
        check("rst_determinant", determinant, W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_led", W'(led), W'(0));
        reset = 1'b0;
        @(negedge clk);

        // Directed matrices.
        mat = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        check("ref_identity", det_ref(), 32'h0000_0001);
        run_matrix(1'b0, 1'b0, 0);

        mat = '{1, 2, 3, 4, 5, 6, 7, 8, 10};
        check("ref_m10", det_ref(), 32'hFFFF_FFFD);
        run_matrix(1'b0, 1'b0, 20);

        mat = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        run_matrix(1'b0, 1'b0, 0);
        check("led_e02", W'(led), W'(16'h0003));

        mat = '{65536, 0, 0, 0, 65536, 0, 0, 0, 1};
        run_matrix(1'b0, 1'b1, 1);

        mat = '{2, 0, 0, 0, 3, 0, 0, 0, 4};
        run_matrix(1'b1, 1'b1, 2);

        // Randomized matrices with gapped input, junk input during CALC/OUT, random backpressure.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 9; i++)
                mat[i] = (r < 4) ? W'($urandom_range(0, 40)) - W'(20) : $urandom;
            run_matrix(1'b1, 1'b1, int'($urandom_range(0, 4)));
            check("led_rand", W'(led), W'(mat[2][15:0]));
        end

        // Asynchronous reset at CALC step 4.
        for (int i = 0; i < 9; i++) mat[i] = $urandom;
        send_elems(9, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_rst_valid", W'(det_valid), W'(0));
        check("abort_rst_busy", W'(busy), W'(0));
        check("abort_rst_in_ready", W'(in_ready), W'(1));
        check("abort_rst_led", W'(led), W'(0));
        @(negedge clk);
        reset = 1'b0;
        expect_quiet("abort_rst_quiet", 20);
        mat = '{2, 0, 0, 0, 3, 0, 0, 0, 4};
        run_matrix(1'b0, 1'b0, 0);

        // Synchronous clear after five elements, with a competing in_valid.
        mat = '{9, 8, 16'h1234, 6, 5, 4, 3, 2, 1};
        send_elems(5, 1'b0);
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("clr_in_ready", W'(in_ready), W'(1));
        check("clr_busy", W'(busy), W'(0));
        check("clr_led_kept", W'(led), W'(16'h1234));
        expect_quiet("clr_quiet", 20);
        mat = '{2, 0, 0, 0, 3, 0, 0, 0, 4};
        run_matrix(1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
